// File: rtl/fft_out_reorder.sv
// Output reorder stage for the 32-point MDC FFT: takes bit-reversed pairs into a
// ping-pong buffer and streams each frame out in natural bin order.
module fft_out_reorder #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_a_re,
    input  logic [DATA_W-1:0] din_a_im,
    input  logic [DATA_W-1:0] din_b_re,
    input  logic [DATA_W-1:0] din_b_im,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout_re,
    output logic [DATA_W-1:0] dout_im,
    output logic [4:0]        dout_idx,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              overflow
);

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Entry address = {bank, bin}
    logic [2*DATA_W-1:0] mem [64];

    logic [3:0] wr_cnt_q;
    logic       wr_bank_q;
    logic       drop_q;
    logic [1:0] full_q, full_d;
    logic       rd_bank_q, rd_bank_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    state_e     state_q, state_d;

    logic       frame_start;
    logic       rd_en;
    logic       rd_last;
    logic       drop_cur;
    logic       wr_en;
    logic       set_full;
    logic       nxt_rd_bank;
    logic [1:0] clr_vec;
    logic [1:0] set_vec;
    logic [1:0] full_avail;
    logic [5:0] wr_addr_a, wr_addr_b;
    logic [5:0] rd_ptr;
    logic [2*DATA_W-1:0] rd_word;

    assign frame_start = din_valid && (wr_cnt_q == 4'd0);
    assign rd_en       = (state_q == StRead);
    assign rd_last     = rd_en && (rd_addr_q == 5'd31);
    assign clr_vec     = rd_last ? (2'b01 << rd_bank_q) : 2'b00;
    // A bank released this cycle is already free for a frame starting this cycle
    assign full_avail  = full_q & ~clr_vec;
    assign drop_cur    = frame_start ? full_avail[wr_bank_q] : drop_q;
    assign wr_en       = din_valid && !drop_cur;
    assign set_full    = wr_en && (wr_cnt_q == 4'd15);
    assign set_vec     = set_full ? (2'b01 << wr_bank_q) : 2'b00;
    assign full_d      = full_avail | set_vec;
    assign nxt_rd_bank = ~rd_bank_q;

    assign wr_addr_a = {wr_bank_q, 1'b0, bitrev4(wr_cnt_q)};
    assign wr_addr_b = {wr_bank_q, 1'b1, bitrev4(wr_cnt_q)};
    assign rd_ptr    = {rd_bank_q, rd_addr_q};
    assign rd_word   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_a] <= {din_a_re, din_a_im};
            mem[wr_addr_b] <= {din_b_re, din_b_im};
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = StRead;
                    rd_addr_d = 5'd0;
                end
            end
            StRead: begin
                if (rd_last) begin
                    rd_bank_d = nxt_rd_bank;
                    rd_addr_d = 5'd0;
                    // Chain straight into the other bank when it is ready: no bubble
                    state_d   = full_d[nxt_rd_bank] ? StRead : StIdle;
                end else begin
                    rd_addr_d = rd_addr_q + 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= 4'd0;
            wr_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            full_q     <= 2'b00;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            state_q    <= StIdle;
            overflow   <= 1'b0;
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            dout_idx   <= 5'd0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
        end else begin
            if (din_valid) begin
                wr_cnt_q <= wr_cnt_q + 4'd1;
            end
            if (frame_start) begin
                drop_q <= drop_cur;
                if (drop_cur) begin
                    overflow <= 1'b1;
                end
            end
            // Dropped frames leave wr_bank alone so bank order tracks read order
            if (set_full) begin
                wr_bank_q <= ~wr_bank_q;
            end
            full_q     <= full_d;
            rd_bank_q  <= rd_bank_d;
            rd_addr_q  <= rd_addr_d;
            state_q    <= state_d;
            dout_valid <= rd_en;
            dout_re    <= rd_en ? rd_word[2*DATA_W-1:DATA_W] : '0;
            dout_im    <= rd_en ? rd_word[DATA_W-1:0] : '0;
            dout_idx   <= rd_en ? rd_addr_q : 5'd0;
            dout_sop   <= rd_en && (rd_addr_q == 5'd0);
            dout_eop   <= rd_en && (rd_addr_q == 5'd31);
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: directed frames, expected bins queued by the stimulus
// and checked by an independent output monitor.
module tb_fft_out_reorder;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din_a_re = '0, din_a_im = '0, din_b_re = '0, din_b_im = '0;
    logic          dout_valid;
    logic [DW-1:0] dout_re, dout_im;
    logic [4:0]    dout_idx;
    logic          dout_sop, dout_eop, overflow;

    fft_out_reorder #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_a_re  (din_a_re),
        .din_a_im  (din_a_im),
        .din_b_re  (din_b_re),
        .din_b_im  (din_b_im),
        .dout_valid(dout_valid),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .dout_idx  (dout_idx),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int vcnt = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    logic [2*DW+6:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] brev4(input int k);
        logic [3:0] v;
        v = k[3:0];
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Monitor: every valid output bin must match the head of the queue
    always @(negedge clk) begin
        logic [2*DW+6:0] e;
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_bin at cycle %0d: got idx %0d re %0h, want none",
                         cyc, dout_idx, dout_re);
            end else begin
                e = exp_q.pop_front();
                check("bin", 64'({dout_re, dout_im, dout_idx, dout_sop, dout_eop}), 64'(e));
            end
            vcnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    // Frame f carries re = f*64 + bin, im = -re
    task automatic push_frame(input int f);
        logic [DW-1:0] re;
        for (int i = 0; i < 32; i++) begin
            re = DW'(f * 64 + i);
            exp_q.push_back({re, -re, 5'(i), (i == 0), (i == 31)});
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ovf_first >= 0 checks overflow right after the first pair is accepted
    task automatic send_frame(input int f, input bit gaps, input bit push, input int ovf_first);
        logic [DW-1:0] re;
        if (push) push_frame(f);
        for (int k = 0; k < 16; k++) begin
            if (gaps && k > 0) idle(1);
            re = DW'(f * 64 + int'(brev4(k)));
            din_valid = 1'b1;
            din_a_re = re;
            din_a_im = -re;
            din_b_re = re + 16'd16;
            din_b_im = -(re + 16'd16);
            @(posedge clk);
            #1;
            if (k == 0 && ovf_first >= 0) check("ovf_first_pair", 64'(overflow), 64'(ovf_first));
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d bins pending, want 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic check_latency(input string name);
        check({name, "_e0"}, 64'(dout_valid), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_e1"}, 64'(dout_valid), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_e2"}, 64'({dout_valid, dout_sop, dout_idx}), 64'({1'b1, 1'b1, 5'd0}));
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({dout_valid, dout_re, dout_im, dout_idx, dout_sop, dout_eop, overflow}),
              64'd0);
    endtask

    initial begin
        idle(3);
        check_zero("reset_state");
        rst = 1'b0;
        idle(2);
        check_zero("post_reset_idle");

        // Single contiguous frame
        send_frame(0, 1'b0, 1'b1, 0);
        check_latency("lat_contig");
        drain();

        // Same frame with 1,0 valid gaps
        send_frame(0, 1'b1, 1'b1, 0);
        check_latency("lat_gaps");
        drain();

        // Four frames at the native rate: one seamless 128-bin stream
        vcnt = 0;
        first_cyc = -1;
        for (int f = 1; f <= 4; f++) begin
            send_frame(f, 1'b0, 1'b1, 0);
            idle(16);
        end
        drain();
        check("stream_count", 64'(vcnt), 64'd128);
        check("stream_span", 64'(last_cyc - first_cyc + 1), 64'd128);
        check("stream_ovf", 64'(overflow), 64'd0);

        // Third frame starts exactly as its bank is released
        send_frame(5, 1'b0, 1'b1, 0);
        send_frame(6, 1'b0, 1'b1, 0);
        idle(16);
        send_frame(7, 1'b0, 1'b1, 0);
        drain();
        check("race_ovf", 64'(overflow), 64'd0);

        // Back-to-back: third frame dropped
        send_frame(8, 1'b0, 1'b1, 0);
        send_frame(9, 1'b0, 1'b1, 0);
        check("b2b_ovf_before", 64'(overflow), 64'd0);
        send_frame(10, 1'b0, 1'b0, 1);
        drain();
        check("b2b_ovf_sticky", 64'(overflow), 64'd1);
        send_frame(11, 1'b0, 1'b1, 1);
        drain();
        check("b2b_ovf_after", 64'(overflow), 64'd1);

        // Reset after pair 7 of a frame
        din_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            din_a_re = DW'(12 * 64 + int'(brev4(k)));
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        check_zero("rst_during_0");
        idle(1);
        check_zero("rst_during_1");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_zero("rst_after");
        end
        send_frame(13, 1'b0, 1'b1, 0);
        check_latency("lat_after_rst");
        drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder stage of the 32-point MDC FFT, directly downstream of the final butterfly stage. It accepts the two-path, bit-reversed output stream of the FFT. Each frame is 16 cycles carrying two complex bins per cycle. The block writes each frame into one half of a ping-pong buffer and streams it out in natural order (bin 0..31) at one bin per cycle. While one bank is read, the next frame fills the other bank.

## Interface
Parameters:
- DATA_W, 16: width of each real/imag component (two's complement).

Ports:
- clk  in  1  one clock; all logic on rising edge.
- rst  in  1  reset is synchronous and active-high.
- din_valid  in  1  a pair is presented this cycle; gaps are allowed between pairs.
- din_a_re, din_a_im  in  DATA_W  upper path sample.
- din_b_re, din_b_im  in  DATA_W  lower path sample.
- dout_valid  out  1  output bin valid.
- dout_re, dout_im  out  DATA_W  output bin.
- dout_idx  out  5  bin index of the current output (0..31).
- dout_sop  out  1  high with bin 0.
- dout_eop  out  1  high with bin 31.
- overflow  out  1  sticky; a frame was dropped.

## Operation
- Input mapping, pair k (k = 0..15, k is the count of accepted pairs in the frame):
  - a writes bin r = bitrev4(k).
  - b writes bin r+16.
  - Example: k=1 gives a → bin 8, b → bin 24.
- Storage: two banks (0, 1), each 32 × 2·DATA_W, with a full[1:0] flag per bank and pointers wr_bank / rd_bank.
- Write side:
  - 4-bit wr_cnt advances on each accepted pair and wraps 15→0.
  - On the pair with wr_cnt==15: full[wr_bank] is set and wr_bank toggles.
  - Frame start (wr_cnt==0 with din_valid): if full[wr_bank] is set, the whole 16-pair frame is dropped.
    - Dropped pairs still advance wr_cnt.
    - No bank write occurs and full is unchanged.
    - overflow is set and stays set until rst.
  - The drop decision is latched at the frame's first pair and holds for all 16 pairs.
- Read FSM, states IDLE and READ:
  - IDLE → READ when full[rd_bank]==1; rd_addr = 0.
  - In READ, one address is issued per cycle, rd_addr 0..31.
  - At rd_addr==31: full[rd_bank] is cleared and rd_bank toggles.
    - If the new rd_bank is full (or becomes full that same cycle), stay in READ with rd_addr = 0. There is no bubble.
    - Otherwise go to IDLE.
- Simultaneous events:
  - A clear of full[x] and a frame-start check on bank x in the same cycle: the clear wins and the frame is accepted.
  - Set of full[x] from the write side and the read of bank x can never coincide, because the bank is not full while being written.
- Output register:
  - dout_* is registered from the bank read; dout_idx equals the registered rd_addr.
  - dout_sop = (idx==0)&valid; dout_eop = (idx==31)&valid.
- Arithmetic: none; data passes bit-exact.
- Reset values:
  - dout_valid, dout_sop, dout_eop, overflow = 0.
  - dout_re, dout_im, dout_idx = 0.
  - wr_cnt = 0, full = 00, wr_bank = rd_bank = 0, FSM = IDLE.
  - Bank contents are not reset.
- rst mid-frame: any partial frame is discarded. The next din_valid is treated as pair k=0.

## Timing
- Write is accepted on the rising edge where din_valid=1. full is set on the same edge as the 16th pair.
- Latency: the first dout_valid (bin 0) is asserted 2 cycles after the cycle presenting the 16th pair, provided the reader was IDLE. There is one cycle of FSM start and one cycle of registered read.
- Sustained rate is one frame per 32 cycles. With contiguous input (16 pairs per 32 cycles, as emitted by the FFT), output is a continuous stream with no gaps and no overflow.
- A frame arriving every 16 cycles back-to-back overflows on the third frame.
- dout_valid stays high for exactly 32 consecutive cycles per frame.

## Test plan
- Single frame, din_valid contiguous 16 cycles; din_a_re = bitrev4(k), din_b_re = bitrev4(k)+16, im = −re.
  - Required: dout_re = 0,1,…,31 on 32 consecutive cycles.
  - Required: dout_idx matches dout_re; sop with 0, eop with 31.
  - Required: first dout_valid 2 cycles after pair 15.
- Four frames, each 16 valid cycles followed by 16 idle cycles.
  - Required: 128 contiguous output bins with no gap, frames in order, overflow = 0.
- Input with gaps (din_valid toggling 1,0).
  - Required: identical output data to the contiguous case; output starts 2 cycles after the 16th accepted pair.
- Three frames back-to-back with no idle cycles.
  - Required: frames 1 and 2 are output intact.
  - Required: frame 3 is dropped and overflow rises on its first pair and stays 1.
  - Required: a frame 4 sent after bank release is output correctly.
- Exact-release race: time frame N+2's first pair to coincide with the cycle where rd_addr==31 of the bank it targets.
  - Required: the frame is accepted, overflow = 0, and its output is correct.
- Assert rst after pair 7 of a frame, then send a full frame.
  - Required: all outputs are 0 during and after reset, no partial frame appears, and the new frame outputs bins 0..31 correctly.
